// File: rtl/proc_run_ctrl_if.sv
// proc_run_ctrl_if -- host descriptor/status and core-side pins of the run
// sequencer, bundled as one interface.
//   slave  : the sequencer (samples start/descriptor/core feedback, drives
//            status and the core's resetl/startpc)
//   master : host + core side (drives start/descriptor, currentpc, dmemout)
// Optional macro PROC_RUN_STALL_EN adds the `stalled` status bit.
interface proc_run_ctrl_if #(
  parameter int WDOG_W = 16
);
  logic              start;
  logic [63:0]       start_addr;
  logic [63:0]       halt_addr;
  logic [63:0]       expected;
  logic              core_resetl;
  logic [63:0]       core_startpc;
  logic [63:0]       core_currentpc;
  logic [63:0]       core_dmemout;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [WDOG_W-1:0] cycle_count;
`ifdef PROC_RUN_STALL_EN
  logic              stalled;

  modport master (
    output start, start_addr, halt_addr, expected, core_currentpc, core_dmemout,
    input  core_resetl, core_startpc, busy, done, pass, timeout, cycle_count, stalled
  );
  modport slave (
    input  start, start_addr, halt_addr, expected, core_currentpc, core_dmemout,
    output core_resetl, core_startpc, busy, done, pass, timeout, cycle_count, stalled
  );
`else
  modport master (
    output start, start_addr, halt_addr, expected, core_currentpc, core_dmemout,
    input  core_resetl, core_startpc, busy, done, pass, timeout, cycle_count
  );
  modport slave (
    input  start, start_addr, halt_addr, expected, core_currentpc, core_dmemout,
    output core_resetl, core_startpc, busy, done, pass, timeout, cycle_count
  );
`endif
endinterface

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl -- run sequencer for the 64-bit single-cycle core.
// Latches a descriptor (start PC, halt PC, expected result), holds the core in
// reset for RESET_CYCLES, lets it run until currentpc >= halt PC (unsigned),
// waits one drain cycle and compares dmemout with the expected value. A
// watchdog ends runs that reach WDOG_LIMIT RUN cycles without halting.
// Ports:
//   CLK    : clock, rising edge
//   resetl : asynchronous active-low reset
//   bus    : proc_run_ctrl_if.slave (start/descriptor in, status out,
//            core_resetl/core_startpc out, core_currentpc/core_dmemout in)
// Optional macro PROC_RUN_STALL_EN: stall detector that ends a run once the
// PC has been unchanged for STALL_CYCLES consecutive RUN cycles (bus.stalled).
module proc_run_ctrl #(
  parameter int                RESET_CYCLES = 2,
  parameter int                WDOG_W       = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT   = 16'h00FF,
  parameter int                STALL_CYCLES = 4
) (
  input logic            CLK,
  input logic            resetl,
  proc_run_ctrl_if.slave bus
);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  if (RESET_CYCLES < 1 || STALL_CYCLES < 1) begin : g_bad_param
    $error("proc_run_ctrl: RESET_CYCLES and STALL_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [63:0]       startpc_q, startpc_d;
  logic [63:0]       halt_q, halt_d;
  logic [63:0]       exp_q, exp_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [WDOG_W-1:0] cyc_q, cyc_d;
  logic              core_rl_q, core_rl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;

  logic halt_hit, wdog_hit, rst_last, accept;

  assign halt_hit = (bus.core_currentpc >= halt_q);
  assign wdog_hit = (cyc_q == WDOG_LIMIT);
  assign rst_last = (rst_cnt_q == RW'(RESET_CYCLES - 1));
  assign accept   = bus.start && (state_q == S_IDLE || state_q == S_DONE);

`ifdef PROC_RUN_STALL_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [63:0]   prev_pc_q;
  logic          stalled_q, stalled_d;
  logic          pc_same, stall_hit;

  // prev_pc_q tracks every cycle so the first RUN cycle already compares
  // against the PC seen while the core was still held in reset.
  assign pc_same   = (bus.core_currentpc == prev_pc_q);
  assign stall_hit = pc_same && (stall_cnt_q == SW'(STALL_CYCLES - 1));
  assign bus.stalled = stalled_q;
`endif

  // State and datapath registers
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q   <= S_IDLE;
      startpc_q <= '0;
      halt_q    <= '0;
      exp_q     <= '0;
      rst_cnt_q <= '0;
      cyc_q     <= '0;
      core_rl_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
`ifdef PROC_RUN_STALL_EN
      stall_cnt_q <= '0;
      prev_pc_q   <= '0;
      stalled_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      startpc_q <= startpc_d;
      halt_q    <= halt_d;
      exp_q     <= exp_d;
      rst_cnt_q <= rst_cnt_d;
      cyc_q     <= cyc_d;
      core_rl_q <= core_rl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      to_q      <= to_d;
`ifdef PROC_RUN_STALL_EN
      stall_cnt_q <= stall_cnt_d;
      prev_pc_q   <= bus.core_currentpc;
      stalled_q   <= stalled_d;
`endif
    end
  end

  // Next state. In RUN: halt > stall > watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_RESET;
      S_RESET:        if (rst_last)  state_d = S_RUN;
      S_RUN: begin
        if (halt_hit)      state_d = S_DRAIN;
`ifdef PROC_RUN_STALL_EN
        else if (stall_hit) state_d = S_DONE;
`endif
        else if (wdog_hit) state_d = S_DONE;
      end
      S_DRAIN:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Registered-output next values
  always_comb begin
    startpc_d = startpc_q;
    halt_d    = halt_q;
    exp_d     = exp_q;
    rst_cnt_d = rst_cnt_q;
    cyc_d     = cyc_q;
    core_rl_d = core_rl_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    to_d      = to_q;
`ifdef PROC_RUN_STALL_EN
    stall_cnt_d = stall_cnt_q;
    stalled_d   = stalled_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          startpc_d = bus.start_addr;
          halt_d    = bus.halt_addr;
          exp_d     = bus.expected;
          rst_cnt_d = '0;
          cyc_d     = '0;
          core_rl_d = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          to_d      = 1'b0;
`ifdef PROC_RUN_STALL_EN
          stall_cnt_d = '0;
          stalled_d   = 1'b0;
`endif
        end
      end
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + RW'(1);
        if (rst_last) core_rl_d = 1'b1;
      end
      S_RUN: begin
`ifdef PROC_RUN_STALL_EN
        stall_cnt_d = pc_same ? stall_cnt_q + SW'(1) : '0;
`endif
        // On halt the count is frozen; DRAIN produces the verdict.
        if (!halt_hit) begin
`ifdef PROC_RUN_STALL_EN
          if (stall_hit) begin
            stalled_d = 1'b1;
            to_d      = 1'b0;
            pass_d    = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            core_rl_d = 1'b0;
          end else
`endif
          if (wdog_hit) begin
            to_d      = 1'b1;
            pass_d    = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            core_rl_d = 1'b0;
          end else begin
            cyc_d = cyc_q + WDOG_W'(1);
          end
        end
      end
      S_DRAIN: begin
        pass_d    = (bus.core_dmemout == exp_q);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        core_rl_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.core_resetl  = core_rl_q;
  assign bus.core_startpc = startpc_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.timeout      = to_q;
  assign bus.cycle_count  = cyc_q;
endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: the bench plays host and core. Each run is
// described by a PC trace (PC seen in each RUN cycle); the model derives the
// run's timeline (halt index, watchdog, drain verdict) from that trace and a
// compare process checks every DUT output on every negative clock edge.
module tb_proc_run_ctrl;
  localparam int RC    = 2;
  localparam int LIM   = 255;
  localparam int BOUND = 2000;

  logic CLK    = 1'b0;
  logic resetl = 1'b0;

  proc_run_ctrl_if #(.WDOG_W(16)) bus ();

  proc_run_ctrl #(
    .RESET_CYCLES(RC), .WDOG_W(16), .WDOG_LIMIT(16'(LIM)), .STALL_CYCLES(4)
  ) dut (
    .CLK(CLK), .resetl(resetl), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Model of the current/last run. t = clock edges since the accepting edge.
  bit          run_seen = 1'b0;
  int          t = 0, t_done = 0, fin_cc = 0, h = -1;
  bit          m_pass = 1'b0, m_to = 1'b0, dm_ok = 1'b1;
  logic [63:0] m_spc = '0, m_halt = '0, m_exp = '0;
  logic [63:0] pc_plan [0:LIM];

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Outcome of a run follows from the first trace index at/above halt.
  task automatic accept();
    run_seen = 1'b1;
    t      = 0;
    m_spc  = bus.start_addr;
    m_halt = bus.halt_addr;
    m_exp  = bus.expected;
    h      = -1;
    for (int j = 0; j <= LIM; j++)
      if (h < 0 && pc_plan[j] >= m_halt) h = j;
    if (h >= 0) begin
      t_done = RC + 2 + h; fin_cc = h; m_to = 1'b0; m_pass = dm_ok;
    end else begin
      t_done = RC + 1 + LIM; fin_cc = LIM; m_to = 1'b1; m_pass = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
    if (!resetl) run_seen = 1'b0;
    else if (bus.start && (!run_seen || t >= t_done)) accept();
    else if (run_seen) t++;
    if (run_seen && t < RC)             bus.core_currentpc = pc_plan[0];
    else if (run_seen && t - RC <= LIM) bus.core_currentpc = pc_plan[t - RC];
    else                                bus.core_currentpc = rnd64();
    if (run_seen && !m_to && t == RC + 1 + h)
      bus.core_dmemout = dm_ok ? m_exp : ~m_exp;
    else
      bus.core_dmemout = rnd64();
  endtask

  always @(negedge CLK) begin
    logic        e_busy, e_done, e_rl, e_pass, e_to;
    logic [63:0] e_spc;
    int          e_cc;
    if (!run_seen) begin
      e_busy = 0; e_done = 0; e_rl = 0; e_pass = 0; e_to = 0; e_spc = '0; e_cc = 0;
    end else begin
      e_done = (t >= t_done);
      e_busy = !e_done;
      e_rl   = (t >= RC) && !e_done;
      e_pass = e_done && m_pass;
      e_to   = e_done && m_to;
      e_spc  = m_spc;
      e_cc   = (t <= RC) ? 0 : ((t - RC < fin_cc) ? t - RC : fin_cc);
    end
    chk("busy",        64'(bus.busy),        64'(e_busy));
    chk("done",        64'(bus.done),        64'(e_done));
    chk("core_resetl", 64'(bus.core_resetl), 64'(e_rl));
    chk("pass",        64'(bus.pass),        64'(e_pass));
    chk("timeout",     64'(bus.timeout),     64'(e_to));
    chk("startpc",     bus.core_startpc,     e_spc);
    chk("cycle_count", 64'(bus.cycle_count), 64'(e_cc));
  end

  task automatic do_run(input logic [63:0] sa, input logic [63:0] ha, input logic [63:0] ex,
                        input bit ok, input bit pokes);
    int n;
    dm_ok = ok;
    bus.start_addr = sa; bus.halt_addr = ha; bus.expected = ex; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.start_addr = rnd64(); bus.halt_addr = rnd64(); bus.expected = rnd64();
    n = 0;
    while (!(run_seen && t >= t_done) && n < BOUND) begin
      bus.start = pokes && ($urandom_range(0, 4) == 0);
      if (bus.start) begin
        bus.start_addr = rnd64(); bus.halt_addr = rnd64(); bus.expected = rnd64();
      end
      step();
      n++;
    end
    bus.start = 1'b0;
    if (n >= BOUND) begin
      total++; bad++;
      $display("FAIL run_bound: got %0d cycles want < %0d", n, BOUND);
    end
  endtask

  initial begin
    logic [63:0] ha;
    int          k, nsteps;
    bus.start = 1'b0; bus.start_addr = '0; bus.halt_addr = '0; bus.expected = '0;
    bus.core_currentpc = '0; bus.core_dmemout = '0;
    for (int j = 0; j <= LIM; j++) pc_plan[j] = '0;

    repeat (3) step();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_core_resetl", 64'(bus.core_resetl), 64'd0);
    #2 resetl = 1'b1;
    step();

    // Halt path: PC advances by 4 per RUN cycle, halt at 0x30 -> 12 cycles
    for (int j = 0; j <= LIM; j++) pc_plan[j] = 64'(4 * j);
    do_run(64'h0, 64'h30, 64'hF, 1'b1, 1'b0);
    chk("halt_cc", 64'(bus.cycle_count), 64'd12);
    chk("halt_pass", 64'(bus.pass), 64'd1);
    chk("halt_to", 64'(bus.timeout), 64'd0);
    repeat (2) step();

    // Result mismatch, then restart with a new descriptor
    do_run(64'h0, 64'h30, 64'hF, 1'b0, 1'b0);
    chk("mism_pass", 64'(bus.pass), 64'd0);
    do_run(64'h0, 64'h58, 64'h123456789abcdef0, 1'b1, 1'b0);
    chk("restart_cc", 64'(bus.cycle_count), 64'd22);
    chk("restart_pass", 64'(bus.pass), 64'd1);

    // Watchdog: PC stuck below halt
    for (int j = 0; j <= LIM; j++) pc_plan[j] = 64'h10;
    do_run(64'h0, 64'h30, 64'h5, 1'b1, 1'b0);
    chk("wdog_cc", 64'(bus.cycle_count), 64'hFF);
    chk("wdog_to", 64'(bus.timeout), 64'd1);
    chk("wdog_pass", 64'(bus.pass), 64'd0);

    // Start already past halt: drain on first RUN edge
    for (int j = 0; j <= LIM; j++) pc_plan[j] = 64'h40 + 64'(4 * j);
    do_run(64'h40, 64'h30, 64'h77, 1'b1, 1'b0);
    chk("bnd_cc", 64'(bus.cycle_count), 64'd0);
    chk("bnd_pass", 64'(bus.pass), 64'd1);

    // Halt on the same edge the watchdog would fire: halt wins
    for (int j = 0; j <= LIM; j++) pc_plan[j] = (j == LIM) ? 64'h30 : 64'h10;
    do_run(64'h0, 64'h30, 64'h99, 1'b1, 1'b0);
    chk("tie_to", 64'(bus.timeout), 64'd0);
    chk("tie_cc", 64'(bus.cycle_count), 64'hFF);

    // Unsigned compare over 64 bits
    for (int j = 0; j <= LIM; j++)
      pc_plan[j] = (j < 5) ? 64'h7FFF_FFFF_FFFF_FFF0 + 64'(j) : 64'h8000_0000_0000_0010;
    do_run(64'h7FFF_FFFF_FFFF_FFF0, 64'h8000_0000_0000_0010, 64'h1, 1'b1, 1'b0);
    chk("uns_cc", 64'(bus.cycle_count), 64'd5);

    // Start pulses while busy are ignored
    for (int j = 0; j <= LIM; j++) pc_plan[j] = 64'(4 * j);
    do_run(64'h0, 64'h80, 64'hABC, 1'b1, 1'b1);
    chk("poke_pass", 64'(bus.pass), 64'd1);
    chk("poke_spc", bus.core_startpc, 64'h0);

    // Asynchronous reset in the middle of RUN
    bus.start_addr = 64'h0; bus.halt_addr = 64'h100; bus.expected = 64'h3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6) step();
    #2 resetl = 1'b0;
    run_seen = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_core_resetl", 64'(bus.core_resetl), 64'd0);
    chk("arst_cc", 64'(bus.cycle_count), 64'd0);
    repeat (2) step();
    #2 resetl = 1'b1;
    step();
    do_run(64'h0, 64'h30, 64'hF, 1'b1, 1'b0);
    chk("post_arst_cc", 64'(bus.cycle_count), 64'd12);

    // Randomised runs
    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(0, 9);
      ha = rnd64() | 64'h0000_1000_0000_0000;
      nsteps = $urandom_range(1, 60);
      for (int j = 0; j <= LIM; j++) begin
        if (k == 0)      pc_plan[j] = ha - 64'd1 - 64'($urandom_range(0, 1000));
        else if (k <= 2) pc_plan[j] = ha + 64'($urandom_range(0, 50));
        else if (j >= nsteps) pc_plan[j] = ha + 64'($urandom_range(0, 3));
        else             pc_plan[j] = ha - 64'd1 - 64'($urandom_range(0, 5000));
      end
      do_run(rnd64(), ha, rnd64(), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
